// File: rtl/smpc_pad_3wire.sv
// SMPC controller-port 3-wire responder: answers TH/TR handshakes with ID, size and a latched JOY snapshot.
// Optional `PAD_TIMEOUT_EN` adds a WAIT timeout counter and an ABORT state.
module smpc_pad_3wire #(
    parameter logic [3:0] PAD_ID     = 4'h0,
    parameter int         DATA_BYTES = 2,
    parameter int         ACK_DLY    = 8,
    parameter int         TIMEOUT    = 40000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CE,
    input  logic [6:0]                PI,
    output logic [6:0]                PO,
    input  logic [8*DATA_BYTES-1:0]   JOY,
    output logic                      FRAME_DONE
);

    localparam int         N_NIB    = 2 + 2 * DATA_BYTES;
    localparam logic [5:0] LAST_IDX = 6'(N_NIB - 1);
    localparam logic [5:0] SAT_IDX  = 6'(N_NIB);
    localparam logic [7:0] DLY_LOAD = 8'(ACK_DLY);
    localparam logic [3:0] SIZE_NIB = 4'(DATA_BYTES);

`ifdef PAD_TIMEOUT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_RESP, ST_ACK, ST_WAIT, ST_ABORT} state_t;
    // The ACK cycle itself counts toward the timeout, hence the minus one.
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT - 1);
    logic [31:0] tmo_reg, tmo_next;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_ACK, ST_WAIT} state_t;
    localparam logic [31:0] TMO_CFG = 32'(TIMEOUT);
    logic unused_timeout;
    assign unused_timeout = ^TMO_CFG;
`endif

    state_t                   state_reg, state_next;
    logic [5:0]               idx_reg, idx_next;
    logic [7:0]               dly_reg, dly_next;
    logic [8*DATA_BYTES-1:0]  snap_reg, snap_next;
    logic [3:0]               nib_reg, nib_next;
    logic                     tl_reg, tl_next;
    logic                     done_reg, done_next;
    logic                     th_old_reg, tr_old_reg;
    logic                     th_edge, tr_edge;
    logic                     unused_pi;
    logic [3:0]               frame_nib [0:63];

    assign unused_pi = ^PI[4:0];
    assign th_edge   = PI[6] ^ th_old_reg;
    assign tr_edge   = PI[5] ^ tr_old_reg;

    // Every possible index maps to a nibble; positions past the frame read as filler.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_nib
            if (gi == 0) begin : g_id
                assign frame_nib[gi] = PAD_ID;
            end else if (gi == 1) begin : g_size
                assign frame_nib[gi] = SIZE_NIB;
            end else if (gi < N_NIB) begin : g_payload
                assign frame_nib[gi] = snap_reg[8*DATA_BYTES-1-4*(gi-2) -: 4];
            end else begin : g_fill
                assign frame_nib[gi] = 4'h0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dly_next   = dly_reg;
        snap_next  = snap_reg;
        nib_next   = nib_reg;
        tl_next    = tl_reg;
        done_next  = 1'b0;
`ifdef PAD_TIMEOUT_EN
        tmo_next   = tmo_reg;
`endif
        // Any TH movement outside IDLE ends the frame and wins over a TR edge.
        if (state_reg != ST_IDLE && th_edge) begin
            state_next = ST_IDLE;
            idx_next   = 6'd0;
            dly_next   = 8'd0;
            nib_next   = 4'hF;
            tl_next    = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (th_edge && !PI[6]) begin
                        snap_next  = JOY;
                        idx_next   = 6'd0;
                        dly_next   = DLY_LOAD;
                        state_next = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dly_reg <= 8'd1) begin
                        dly_next   = 8'd0;
                        nib_next   = frame_nib[idx_reg];
                        state_next = ST_ACK;
                    end else begin
                        dly_next = dly_reg - 8'd1;
                    end
                end
                ST_ACK: begin
                    tl_next   = ~tl_reg;
                    done_next = (idx_reg == LAST_IDX);
                    if (idx_reg != SAT_IDX) begin
                        idx_next = idx_reg + 6'd1;
                    end
`ifdef PAD_TIMEOUT_EN
                    tmo_next = TMO_LOAD;
`endif
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tr_edge) begin
                        dly_next   = DLY_LOAD;
                        state_next = ST_RESP;
                    end
`ifdef PAD_TIMEOUT_EN
                    else if (tmo_reg <= 32'd1) begin
                        tmo_next   = 32'd0;
                        nib_next   = 4'hF;
                        tl_next    = 1'b1;
                        state_next = ST_ABORT;
                    end else begin
                        tmo_next = tmo_reg - 32'd1;
                    end
                end
                ST_ABORT: begin
                    state_next = ST_ABORT;
`endif
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 6'd0;
            dly_reg    <= 8'd0;
            snap_reg   <= '0;
            nib_reg    <= 4'hF;
            tl_reg     <= 1'b1;
            done_reg   <= 1'b0;
            th_old_reg <= 1'b1;
            tr_old_reg <= 1'b1;
`ifdef PAD_TIMEOUT_EN
            tmo_reg    <= 32'd0;
`endif
        end else if (CE) begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            dly_reg    <= dly_next;
            snap_reg   <= snap_next;
            nib_reg    <= nib_next;
            tl_reg     <= tl_next;
            done_reg   <= done_next;
            th_old_reg <= PI[6];
            tr_old_reg <= PI[5];
`ifdef PAD_TIMEOUT_EN
            tmo_reg    <= tmo_next;
`endif
        end
    end

    assign PO         = {2'b11, tl_reg, nib_reg};
    assign FRAME_DONE = done_reg;

endmodule

// File: tb/tb_smpc_pad_3wire.sv
// Directed + randomized bench for smpc_pad_3wire with a frame-level reference model.
// Timeout checks are compiled only when PAD_TIMEOUT_EN is defined.
module tb_smpc_pad_3wire;

    localparam int DB = 2;
    localparam int NN = 2 + 2 * DB;
    localparam logic [3:0] ID = 4'h0;

    logic        CLK = 1'b0;
    logic        RST, CE;
    logic [6:0]  PI;
    logic [6:0]  PO;
    logic [15:0] JOY;
    logic        FRAME_DONE;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    int          m_idx;
    logic        m_tl;
    logic [3:0]  m_data;
    logic [15:0] m_snap;

    smpc_pad_3wire #(
        .PAD_ID(ID), .DATA_BYTES(DB), .ACK_DLY(8), .TIMEOUT(100)
    ) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .PI(PI), .PO(PO),
        .JOY(JOY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (FRAME_DONE === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame content as the protocol defines it: ID, size, payload nibbles MSB first, then zeros.
    function automatic logic [3:0] model_nib(input int idx);
        if (idx == 0) return ID;
        if (idx == 1) return 4'(DB);
        if (idx < NN) return 4'((m_snap >> (4 * (2 * DB - 1 - (idx - 2)))) & 16'hF);
        return 4'h0;
    endfunction

    // Called in the CE cycle t that carries a TH fall or TR edge.
    task automatic ack_step(input int stall);
        logic [3:0] exp_nib;
        logic       exp_done;
        exp_nib  = model_nib(m_idx);
        exp_done = (m_idx == NN - 1);
        repeat (3) tick();
        if (stall > 0) begin
            CE = 1'b0;
            repeat (stall) tick();
            chk("stall_hold", PO, {2'b11, m_tl, m_data});
            CE = 1'b1;
        end
        repeat (5) tick();
        chk("pre_data_hold", PO, {2'b11, m_tl, m_data});
        tick();
        chk("nibble", PO[3:0], exp_nib);
        chk("tl_before_ack", PO[4], m_tl);
        m_data = exp_nib;
        m_tl   = ~m_tl;
        tick();
        chk("tl_toggle", {PO[4], PO[3:0]}, {m_tl, m_data});
        chk("done_at_ack", FRAME_DONE, exp_done);
        tick();
        chk("done_cleared", FRAME_DONE, 1'b0);
        m_idx = (m_idx + 1 > NN) ? NN : m_idx + 1;
        $display("ack idx=%0d nib=%h tl=%0b done=%0b", m_idx - 1, exp_nib, m_tl, exp_done);
    endtask

    task automatic start_frame(input logic [15:0] joy, input int stall);
        JOY    = joy;
        m_snap = joy;
        m_idx  = 0;
        m_data = 4'hF;
        m_tl   = 1'b1;
        PI[6]  = 1'b0;
        ack_step(stall);
    endtask

    task automatic req(input int stall);
        PI[5] = ~PI[5];
        ack_step(stall);
    endtask

    task automatic end_frame();
        PI[6] = 1'b1;
        tick();
        chk("th_rise_idle", PO, 7'h7F);
        m_data = 4'hF;
        m_tl   = 1'b1;
        m_idx  = 0;
    endtask

    initial begin
        int d0;
        RST = 1'b1; CE = 1'b1; PI = 7'h7F; JOY = 16'hFFFF;
        repeat (2) tick();
        chk("reset_po", PO, 7'h7F);
        chk("reset_done", FRAME_DONE, 1'b0);
        RST = 1'b0;
        repeat (3) tick();
        chk("idle_po", PO, 7'h7F);

        // Full frame with 50-cycle TR spacing; ID/size then FF7F payload.
        d0 = done_cnt;
        start_frame(16'hFF7F, 0);
        repeat (39) tick();
        for (int r = 0; r < 5; r++) begin
            req(0);
            repeat (39) tick();
        end
        chk("full_done_count", done_cnt - d0, 1);
        end_frame();

        // Snapshot stays frozen while JOY moves mid-frame.
        start_frame(16'hFF7F, 0);
        req(0);
        JOY = 16'h0000;
        for (int r = 0; r < 4; r++) req(0);
        end_frame();
        start_frame(16'h0000, 0);
        for (int r = 0; r < 5; r++) req(0);
        end_frame();

        // TH rise together with a TR edge after two acknowledges.
        d0 = done_cnt;
        start_frame(16'h1234, 0);
        req(0);
        PI[6] = 1'b1;
        PI[5] = ~PI[5];
        tick();
        chk("abort_po", PO, 7'h7F);
        repeat (15) tick();
        chk("abort_no_toggle", PO, 7'h7F);
        chk("abort_no_done", done_cnt - d0, 0);
        m_data = 4'hF; m_tl = 1'b1; m_idx = 0;
        start_frame(16'hA5C3, 0);
        req(0);
        end_frame();

        // Overrun: acknowledges continue past the frame with zero filler.
        d0 = done_cnt;
        start_frame(16'h9E61, 0);
        for (int r = 0; r < 8; r++) req(0);
        chk("overrun_done_count", done_cnt - d0, 1);
        end_frame();

        // Randomized frames with CE stalls and mid-frame JOY changes.
        for (int f = 0; f < 6; f++) begin
            int nreq, chg;
            nreq = int'($urandom_range(0, 8));
            chg  = int'($urandom_range(0, 8));
            start_frame(16'($urandom), int'($urandom_range(0, 2)));
            for (int r = 0; r < nreq; r++) begin
                if (r == chg) JOY = 16'($urandom);
                repeat ($urandom_range(0, 20)) tick();
                req(int'($urandom_range(0, 3)));
            end
            end_frame();
        end

`ifdef PAD_TIMEOUT_EN
        // No TR after the first acknowledge: ABORT at ACK+100, TR then ignored.
        start_frame(16'h5A5A, 0);
        repeat (97) tick();
        chk("pre_timeout", PO, {2'b11, m_tl, m_data});
        tick();
        chk("timeout_po", PO[4:0], 5'h1F);
        for (int r = 0; r < 3; r++) begin
            PI[5] = ~PI[5];
            repeat (12) tick();
            chk("abort_ignores_tr", PO, 7'h7F);
        end
        end_frame();
        start_frame(16'hC3C3, 0);
        req(0);
        end_frame();
`else
        // Without a timeout, WAIT holds until the next TR edge.
        start_frame(16'h5A5A, 0);
        repeat (150) tick();
        chk("wait_holds", PO, {2'b11, m_tl, m_data});
        req(0);
        end_frame();
`endif

        // Reset with CE low still clears a frame in progress.
        start_frame(16'h0F0F, 0);
        req(0);
        CE = 1'b0; RST = 1'b1; PI = 7'h7F;
        tick();
        chk("reset_no_ce_po", PO, 7'h7F);
        chk("reset_no_ce_done", FRAME_DONE, 1'b0);
        RST = 1'b0; CE = 1'b1;
        tick();
        m_data = 4'hF; m_tl = 1'b1; m_idx = 0;
        start_frame(16'h7E81, 0);
        req(0);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
